// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared edge/center-aligned counter, shadowed
// period/duty/mode configuration loaded at the period boundary, per-channel
// output polarity and a one-cycle update strobe.
module pwm_multi #(
  parameter int unsigned   CH          = 4,
  parameter int unsigned   CW          = 8,
  parameter int unsigned   PERIOD_INIT = 9,
  parameter logic [CH-1:0] POL         = '0,
  localparam int unsigned  AW          = $clog2(CH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          center,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  output logic [CH-1:0] pwm,
  output logic          upd,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dir_q, dir_d;      // 1 = counting down (center mode)
  logic [CW-1:0]         per_s_q, per_s_d;
  logic [CW-1:0]         per_a_q, per_a_d;
  logic [CH-1:0][CW-1:0] duty_s_q, duty_s_d;
  logic [CH-1:0][CW-1:0] duty_a_q, duty_a_d;
  logic                  mode_a_q, mode_a_d;
  logic [CH-1:0]         pwm_q, pwm_d;
  logic                  upd_q, upd_d;
  logic                  bnd_c;

  // Period boundary: last cycle of the current period in the active mode
  always_comb begin
    bnd_c = 1'b0;
    if (!mode_a_q) begin
      bnd_c = (cnt_q == per_a_q);
    end else if (per_a_q == '0) begin
      bnd_c = 1'b1;
    end else begin
      // per_a==1 never reaches a down-counting cnt==1, so its top is the boundary
      bnd_c = (cnt_q == CW'(1)) && (dir_q || (per_a_q == CW'(1)));
    end
  end

  // Shadow registers take config writes; out-of-range addresses are dropped
  always_comb begin
    per_s_d  = per_s_q;
    duty_s_d = duty_s_q;
    if (wr_en && (wr_addr == AW'(CH))) begin
      per_s_d = wr_data;
    end
    for (int n = 0; n < CH; n++) begin
      if (wr_en && (wr_addr == AW'(n))) begin
        duty_s_d[n] = wr_data;
      end
    end
  end

  // Counter, active-register loading, compare and output generation
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    per_a_d  = per_a_q;
    duty_a_d = duty_a_q;
    mode_a_d = mode_a_q;
    pwm_d    = POL;
    upd_d    = 1'b0;
    if (!en) begin
      // Idle: actives track shadows so a restart uses the latest config
      cnt_d    = '0;
      dir_d    = 1'b0;
      per_a_d  = per_s_q;
      duty_a_d = duty_s_q;
      mode_a_d = center;
    end else begin
      for (int n = 0; n < CH; n++) begin
        pwm_d[n] = POL[n] ^ (cnt_q < duty_a_q[n]);
      end
      if (bnd_c) begin
        // Load uses pre-edge shadows; a same-cycle write waits a period
        per_a_d  = per_s_q;
        duty_a_d = duty_s_q;
        mode_a_d = center;
        cnt_d    = '0;
        dir_d    = 1'b0;
        upd_d    = 1'b1;
      end else if (!mode_a_q || (!dir_q && (cnt_q != per_a_q))) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q - CW'(1);
        dir_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      per_s_q  <= CW'(PERIOD_INIT);
      per_a_q  <= CW'(PERIOD_INIT);
      duty_s_q <= '0;
      duty_a_q <= '0;
      mode_a_q <= 1'b0;
      pwm_q    <= POL;
      upd_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      per_s_q  <= per_s_d;
      per_a_q  <= per_a_d;
      duty_s_q <= duty_s_d;
      duty_a_q <= duty_a_d;
      mode_a_q <= mode_a_d;
      pwm_q    <= pwm_d;
      upd_q    <= upd_d;
    end
  end

  assign pwm   = pwm_q;
  assign upd   = upd_q;
  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: vector table, directed corner cases and
// randomized traffic against a period/phase-based reference model.
module tb_pwm_multi;

  localparam int unsigned CH  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned AW  = 3;
  localparam logic [3:0]  POL = 4'b1010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          center;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [CH-1:0] pwm;
  logic          upd;
  logic [CW-1:0] cnt_o;

  int n_vec = 0;
  int n_bad = 0;

  pwm_multi #(.CH(CH), .CW(CW), .PERIOD_INIT(9), .POL(POL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .center(center), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .pwm(pwm), .upd(upd), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period plus period length
  int         m_p;
  int         m_per_s, m_per_a;
  int         m_duty_s [CH];
  int         m_duty_a [CH];
  logic       m_mode;
  logic [3:0] m_pwm;
  logic       m_upd;

  function automatic int m_len();
    if (!m_mode) return m_per_a + 1;
    if (m_per_a == 0) return 1;
    return 2 * m_per_a;
  endfunction

  function automatic int m_cnt();
    if (!m_mode || m_p <= m_per_a) return m_p;
    return 2 * m_per_a - m_p;
  endfunction

  task automatic model_reset();
    m_p = 0; m_per_s = 9; m_per_a = 9; m_mode = 1'b0;
    for (int n = 0; n < CH; n++) begin m_duty_s[n] = 0; m_duty_a[n] = 0; end
    m_pwm = POL; m_upd = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] np;
    int c;
    c  = m_cnt();
    np = POL;
    if (en) for (int n = 0; n < CH; n++) np[n] = POL[n] ^ (c < m_duty_a[n]);
    if (!en) begin
      m_p = 0; m_per_a = m_per_s; m_duty_a = m_duty_s; m_mode = center; m_upd = 1'b0;
    end else if (m_p == m_len() - 1) begin
      m_p = 0; m_per_a = m_per_s; m_duty_a = m_duty_s; m_mode = center; m_upd = 1'b1;
    end else begin
      m_p++; m_upd = 1'b0;
    end
    if (wr_en) begin
      if (int'(wr_addr) < CH) m_duty_s[wr_addr] = int'(wr_data);
      else if (int'(wr_addr) == CH) m_per_s = int'(wr_data);
    end
    m_pwm = np;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cnt_o", 32'(cnt_o), 32'(m_cnt()));
    check("pwm", 32'(pwm), 32'(m_pwm));
    check("upd", 32'(upd), 32'(m_upd));
  endtask

  task automatic set_in(input logic e, input logic c, input logic w,
                        input logic [AW-1:0] a, input logic [CW-1:0] d);
    en = e; center = c; wr_en = w; wr_addr = a; wr_data = d;
  endtask

  typedef struct {
    logic          en;
    logic          center;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    logic [CW-1:0] e_cnt;
    logic [3:0]    e_pwm;
    logic          e_upd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int hi, uc;
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 3'd0, 8'd3,   8'd0, 4'b1010, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 3'd4, 8'd3,   8'd0, 4'b1010, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'd5, 8'd77,  8'd0, 4'b1010, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd1, 4'b1011, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd2, 4'b1011, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd3, 4'b1011, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 4'b1010, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'd1, 8'd200, 8'd1, 4'b1011, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd2, 4'b1011, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd3, 4'b1011, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 4'b1010, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0,   8'd1, 4'b1001, 1'b0};

    // Reset state
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    #12;
    check("rst_pwm", 32'(pwm), 32'(POL));
    check("rst_cnt", 32'(cnt_o), 0);
    check("rst_upd", 32'(upd), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: idle config writes, edge-mode run, full-on channel load
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].en, tbl[i].center, tbl[i].wr_en, tbl[i].addr, tbl[i].data);
      tick();
      check("tbl_cnt", 32'(cnt_o), 32'(tbl[i].e_cnt));
      check("tbl_pwm", 32'(pwm), 32'(tbl[i].e_pwm));
      check("tbl_upd", 32'(upd), 32'(tbl[i].e_upd));
    end

    // Period 0 in edge mode: boundary every cycle
    set_in(1'b1, 1'b0, 1'b1, 3'd4, 8'd0); tick();
    set_in(1'b1, 1'b0, 1'b1, 3'd0, 8'd1); tick();
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("p0_upd", 32'(upd), 1);
      check("p0_cnt", 32'(cnt_o), 0);
      check("p0_pwm0", 32'(pwm[0]), 1);
    end
    set_in(1'b1, 1'b0, 1'b1, 3'd0, 8'd0); tick();
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    check("p0_pwm0_off", 32'(pwm[0]), 0);

    // Center mode, period 5, duty0 2: 3 active cycles, upd every 10
    set_in(1'b1, 1'b1, 1'b1, 3'd4, 8'd5); tick();
    set_in(1'b1, 1'b1, 1'b1, 3'd0, 8'd2); tick();
    set_in(1'b1, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 25; i++) tick();
    hi = 0; uc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      hi += int'(pwm[0]);
      uc += int'(upd);
    end
    check("ctr_hi", 32'(hi), 3);
    check("ctr_upd", 32'(uc), 1);

    // Async reset mid-period, no clock edge involved
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm), 32'(POL));
    check("arst_cnt", 32'(cnt_o), 0);
    check("arst_upd", 32'(upd), 0);
    model_reset();
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // en dropped mid-period, idle write, ignored address, restart
    set_in(1'b0, 1'b0, 1'b1, 3'd3, 8'd4); tick();
    check("idle_pwm", 32'(pwm), 32'(POL));
    check("idle_cnt", 32'(cnt_o), 0);
    set_in(1'b0, 1'b0, 1'b1, 3'd5, 8'd1); tick();
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      hi += int'(!pwm[3]);
    end
    check("restart_lo3", 32'(hi), 4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      logic [CW-1:0] d;
      en = ($urandom % 25) != 0;
      if ($urandom % 60 == 0) center = ~center;
      wr_en = ($urandom % 6) == 0;
      a = AW'($urandom % 8);
      if (a == 3'd4) d = ($urandom % 40 == 0) ? 8'd255 : CW'($urandom % 13);
      else           d = CW'($urandom % 16);
      wr_addr = a;
      wr_data = d;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator with runtime-programmable period and per-channel duty.
- One shared period counter; supports edge-aligned and center-aligned modes.
- Config writes land in shadow registers, which load glitch-free at the period boundary.
- Per-channel output polarity and a boundary strobe for software or DMA sync.
- Sits between the register/config bus and the motor, LED or buzzer pins.

Parameters:
- CH, 4, number of PWM channels (1..16).
- CW, 8, counter, period and duty width in bits.
- PERIOD_INIT, 9, reset value of the period register (must be < 2^CW).
- POL, {CH{1'b0}}, per-channel polarity mask; bit=1 means active-low output (idle level = 1).
- AW (localparam), $clog2(CH+1), config address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 = counter held, outputs idle
- center  in  1  mode request: 0 = edge-aligned, 1 = center-aligned; latched at boundary
- wr_en  in  1  config write strobe, one cycle
- wr_addr  in  AW  0..CH-1 = duty of channel n; CH = period; other values ignored
- wr_data  in  CW  write data
- pwm  out  CH  PWM outputs, registered
- upd  out  1  one-cycle pulse when shadow registers load into active registers
- cnt_o  out  CW  current counter value, for debug and verification

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - cnt=0, dir=up.
  - period shadow and active = PERIOD_INIT; all duty shadow and active = 0.
  - mode_a=0, pwm=POL, upd=0.
- Writes: wr_en=1 stores wr_data into the addressed shadow register at the clock edge. Active registers never change from a write directly.
- Edge mode (mode_a=0):
  - cnt runs 0,1,..,per_a then wraps to 0; period = per_a+1 cycles.
  - Boundary = the edge where cnt==per_a.
- Center mode (mode_a=1):
  - cnt runs 0,1,..,per_a,per_a-1,..,1 then back to 0; period = 2*per_a cycles.
  - Boundary = the edge where cnt==1 and dir=down.
  - per_a==0: cnt stays 0 and every edge is a boundary.
- At a boundary edge:
  - duty_a[n] <= duty_s[n], per_a <= per_s, mode_a <= center.
  - cnt <= 0, dir <= up, upd=1 for exactly that one following cycle.
- Compare: active[n] = (cnt < duty_a[n]) using unsigned CW-bit compare.
- Output: pwm[n] <= POL[n] ^ active[n] each edge while en=1, so pwm lags cnt by one cycle.
  - duty 0 = always idle.
  - duty > per_a = always active.
  - Center mode, 1 <= duty <= per_a: active for 2*duty-1 cycles per period, symmetric about cnt=0.
  - When per_a = 2^CW-1, the maximum duty gives one idle cycle per edge-mode period. This is accepted.
- en=0:
  - cnt=0, dir=up, pwm=POL, upd=0.
  - All active registers follow their shadows every cycle, so new config applies at once on restart.
  - en 0->1: counting starts at cnt=0 with the current active values; the first boundary follows the normal rules.
- en deasserted mid-period: the next edge forces the idle state. No partial-period completion.
- Write in the same cycle as a boundary: the load uses the old shadow value. The new value waits for the next boundary.
- Period reduced below the current cnt: impossible, because per_a only changes at a boundary, when cnt restarts at 0.
- Mode change only at a boundary; dir is always up after the switch.
- wr_addr > CH: the write is ignored and no state changes.

Test Plan (CH=4, CW=8, PERIOD_INIT=9, POL=4'b1010 unless noted):
1. Reset, en=0, write duty0=3, duty1=10, duty2=0; then en=1 in edge mode -> pwm[0] high 3 of every 10 cycles; pwm[1] constant 0 (active-low full on); pwm[2] constant 0; upd every 10 cycles, first on the edge cnt_o 9->0.
2. en=1, duty0=3; write duty0=7 at cnt=4 -> the current period still shows 3 high cycles; from cnt=0 after the next upd, 7 high cycles. A write issued on the boundary edge itself takes effect one period later.
3. Write period=5 and center=1 mid-period -> both apply after the current edge-mode boundary; then cnt_o follows 0,1,2,3,4,5,4,3,2,1 repeating; duty0=2 gives 3 high cycles (cnt 1,0,1); upd every 10 cycles.
4. Edge mode with period=0 -> upd held high every cycle, cnt_o=0; duty0=1 -> pwm[0]=1 constant; duty0=0 -> pwm[0]=0.
5. rst_n pulsed low mid-period at cnt=6 -> pwm=4'b1010, cnt_o=0, upd=0 immediately with no clock; shadows return to defaults (period 9, duties 0).
6. en dropped at cnt=5 -> next edge pwm=POL, cnt_o=0; write duty3=4 while en=0 -> after en=1, pwm[3] shows 4 active (low) cycles in the first period. A write to wr_addr=5 has no effect.
